axi_lite_sram: RTL and testbench

- Behavioural AXI4-Lite SRAM slave, directly downstream of the load/store unit on its `sram` bus.
- Accepts load/store transactions, holds a word-organised memory array and returns read data or write responses after a configurable latency.
- Lane-0 data convention:
  - Read data is returned right-justified, byte/half extraction starting at bit 0.
  - Write data and strobe arrive right-justified; this block aligns them to the addressed byte lane.

---
 rtl/axi_lite_sram.sv | 177 +++++++++++++++++
 tb/tb_axi_lite_sram.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram.sv
// AXI4-Lite word-organised SRAM slave: independent read/write FSMs, byte-lane alignment, DECERR outside the window.
// Optional build macro SRAM_RAND_DELAY_EN adds 0-7 LFSR-chosen extra cycles to each transaction's latency.
module axi_lite_sram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sram_araddr,
  input  logic        sram_arvalid,
  output logic        sram_arready,
  output logic [31:0] sram_rdata,
  output logic [1:0]  sram_rresp,
  output logic        sram_rvalid,
  input  logic        sram_rready,
  input  logic [31:0] sram_awaddr,
  input  logic        sram_awvalid,
  output logic        sram_awready,
  input  logic [31:0] sram_wdata,
  input  logic [3:0]  sram_wstrb,
  input  logic        sram_wvalid,
  output logic        sram_wready,
  output logic [1:0]  sram_bresp,
  output logic        sram_bvalid,
  input  logic        sram_bready
);

  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_DECERR = 2'b11;
  localparam int unsigned       IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned       CNT_W       = 16;
  localparam logic [32:0]       END_ADDR    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  RD_INIT     = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  WR_INIT     = CNT_W'(WR_LAT - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0]      mem [DEPTH_WORDS];
  logic [CNT_W-1:0] lat_extra;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so each handshake samples a fresh value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat_extra = CNT_W'(lfsr[2:0]);
`else
  assign lat_extra = '0;
`endif

  r_state_t         r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= R_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      sram_arready <= 1'b0;
      sram_rvalid  <= 1'b0;
      sram_rdata   <= '0;
      sram_rresp   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (sram_arready && sram_arvalid) begin
            r_addr       <= sram_araddr;
            r_cnt        <= RD_INIT + lat_extra;
            sram_arready <= 1'b0;
            r_state      <= R_WAIT;
          end else begin
            sram_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_cnt == '0) begin
            // Sampled with the pre-write array contents if a write commits on this same edge
            if (in_range(r_addr)) begin
              sram_rdata <= mem[word_idx(r_addr)] >> {r_addr[1:0], 3'b000};
              sram_rresp <= RESP_OKAY;
            end else begin
              sram_rdata <= '0;
              sram_rresp <= RESP_DECERR;
            end
            sram_rvalid <= 1'b1;
            r_state     <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        R_RESP: begin
          if (sram_rready) begin
            sram_rvalid  <= 1'b0;
            sram_arready <= 1'b1;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  w_state_t         w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_err;
  logic             w_hs;
  logic [31:0]      w_data_al;
  logic [3:0]       w_strb_al;

  // Address and data are only taken together; reset also masks the combinational ready
  assign w_hs         = rst && (w_state == W_IDLE) && sram_awvalid && sram_wvalid;
  assign sram_awready = w_hs;
  assign sram_wready  = w_hs;
  assign w_data_al    = sram_wdata << {sram_awaddr[1:0], 3'b000};
  assign w_strb_al    = sram_wstrb << sram_awaddr[1:0];

  always_ff @(posedge clk) begin
    if (w_hs && in_range(sram_awaddr)) begin
      for (int k = 0; k < 4; k++) begin
        if (w_strb_al[k]) mem[word_idx(sram_awaddr)][8*k +: 8] <= w_data_al[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state     <= W_IDLE;
      w_cnt       <= '0;
      w_err       <= 1'b0;
      sram_bvalid <= 1'b0;
      sram_bresp  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (w_hs) begin
            w_err   <= !in_range(sram_awaddr);
            w_cnt   <= WR_INIT + lat_extra;
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt == '0) begin
            sram_bvalid <= 1'b1;
            sram_bresp  <= w_err ? RESP_DECERR : RESP_OKAY;
            w_state     <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 1'b1;
          end
        end
        W_RESP: begin
          if (sram_bready) begin
            sram_bvalid <= 1'b0;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: transaction-level reference model, per-cycle compare, directed and random traffic.
module tb_axi_lite_sram;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          RL    = 1;
  localparam int          WL    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  always #5 clk = ~clk;

  axi_lite_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RL), .WR_LAT(WL)) dut (
    .clk(clk), .rst(rst),
    .sram_araddr(araddr), .sram_arvalid(arvalid), .sram_arready(arready),
    .sram_rdata(rdata), .sram_rresp(rresp), .sram_rvalid(rvalid), .sram_rready(rready),
    .sram_awaddr(awaddr), .sram_awvalid(awvalid), .sram_awready(awready),
    .sram_wdata(wdata), .sram_wstrb(wstrb), .sram_wvalid(wvalid), .sram_wready(wready),
    .sram_bresp(bresp), .sram_bvalid(bvalid), .sram_bready(bready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];
  int          cyc = 0;
  int          r_ph = 0, w_ph = 0, r_due = 0, w_due = 0;
  logic [31:0] r_a = '0;
  logic        ar_e = 1'b0, rv_e = 1'b0, bv_e = 1'b0;
  logic [31:0] rd_e = '0;
  logic [1:0]  rr_e = '0, br_e = '0;
  bit          rd_known = 1'b0;
  bit          ar_acc = 1'b0, w_acc = 1'b0;
  bit          checking = 1'b0;

  function automatic bit inr(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ph = 0; w_ph = 0; ar_e = 1'b0; rv_e = 1'b0; bv_e = 1'b0;
      ar_acc = 1'b0; w_acc = 1'b0;
    end else begin
      cyc++;
      ar_acc = 1'b0;
      w_acc  = 1'b0;
      // Read side first: a capture on this edge sees the array before this edge's write
      if (r_ph == 0) begin
        if (ar_e && arvalid) begin
          r_a = araddr; r_due = cyc + RL; r_ph = 1; ar_e = 1'b0; ar_acc = 1'b1;
        end else ar_e = 1'b1;
      end else if (r_ph == 1) begin
        if (cyc == r_due) begin
          if (inr(r_a)) begin
            rd_e = mm[widx(r_a)] >> (8 * int'(r_a[1:0]));
            rr_e = 2'b00;
            rd_known = mk[widx(r_a)];
          end else begin
            rd_e = '0; rr_e = 2'b11; rd_known = 1'b1;
          end
          rv_e = 1'b1; r_ph = 2;
        end
      end else if (rready) begin
        rv_e = 1'b0; r_ph = 0; ar_e = 1'b1;
      end
      if (w_ph == 0) begin
        if (awvalid && wvalid) begin
          if (inr(awaddr)) begin
            for (int k = 0; k < 4; k++) begin
              int b;
              b = k - int'(awaddr[1:0]);
              if (b >= 0 && wstrb[b]) mm[widx(awaddr)][8*k +: 8] = wdata[8*b +: 8];
            end
            if (awaddr[1:0] == 2'b00 && wstrb == 4'hF) mk[widx(awaddr)] = 1'b1;
            br_e = 2'b00;
          end else br_e = 2'b11;
          w_due = cyc + WL; w_ph = 1; w_acc = 1'b1;
        end
      end else if (w_ph == 1) begin
        if (cyc == w_due) begin bv_e = 1'b1; w_ph = 2; end
      end else if (bready) begin
        bv_e = 1'b0; w_ph = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      chk1("arready", arready, ar_e);
      chk1("rvalid", rvalid, rv_e);
      if (rv_e && rd_known) chk("rdata", rdata, rd_e);
      if (rv_e) chk("rresp", {30'b0, rresp}, {30'b0, rr_e});
      chk1("awready", awready, rst && w_ph == 0 && awvalid && wvalid);
      chk1("wready", wready, rst && w_ph == 0 && awvalid && wvalid);
      chk1("bvalid", bvalid, bv_e);
      if (bv_e) chk("bresp", {30'b0, bresp}, {30'b0, br_e});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tmo(input string nm, input int t);
    n_chk++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, required < 50", nm, t);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int t;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!w_acc && t < 50);
    tmo("aw_handshake", t);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    tmo("bvalid_wait", lat);
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    int t;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!ar_acc && t < 50);
    tmo("ar_handshake", t);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    tmo("rvalid_wait", lat);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] oob [4];
    oob[0] = BASE - 32'd4; oob[1] = BASE + 32'(4 * DEPTH); oob[2] = 32'h0000_0010; oob[3] = 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) return oob[$urandom_range(0, 3)];
    return BASE + 32'($urandom_range(0, 63));
  endfunction

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!arvalid || ar_acc) begin
        arvalid = ($urandom_range(0, 2) == 0);
        araddr  = rand_addr();
      end
      rready = ($urandom_range(0, 2) != 0);
      if (w_acc) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (!awvalid && $urandom_range(0, 2) == 0) begin awvalid = 1'b1; awaddr = rand_addr(); end
      if (!wvalid && $urandom_range(0, 2) == 0) begin
        wvalid = 1'b1; wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
      end
      bready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  logic [31:0] d;
  logic [1:0]  rs;
  int          lat;

  initial begin
    #200_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mk[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;
    @(posedge clk); #1;
    chk1("idle_arready", arready, 1'b1);
    chk1("idle_rvalid", rvalid, 1'b0);
    chk1("idle_bvalid", bvalid, 1'b0);
    chk1("idle_awready", awready, 1'b0);
    chk1("idle_wready", wready, 1'b0);

    // full-word write then read back, unit latency
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rs, lat);
    chk("wr_bresp", {30'b0, rs}, 32'd0);
    chk("wr_latency", 32'(lat), 32'd1);
    axi_read(32'h8000_0010, d, rs, lat);
    chk("rd_data", d, 32'hDEAD_BEEF);
    chk("rd_rresp", {30'b0, rs}, 32'd0);
    chk("rd_latency", 32'(lat), 32'd1);

    // byte store into the third lane
    axi_write(32'h8000_0010, 32'h1122_3344, 4'hF, rs, lat);
    axi_write(32'h8000_0012, 32'h0000_0055, 4'h1, rs, lat);
    chk("byte_bresp", {30'b0, rs}, 32'd0);
    axi_read(32'h8000_0010, d, rs, lat);
    chk("byte_word", d, 32'h1155_3344);
    axi_read(32'h8000_0012, d, rs, lat);
    chk("byte_load", d, 32'h0000_1155);
    axi_read(32'h8000_0013, d, rs, lat);
    chk("byte_load_top", d, 32'h0000_0011);

    // zero-strobe write changes nothing but still answers OKAY
    axi_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, rs, lat);
    chk("zstrb_bresp", {30'b0, rs}, 32'd0);
    axi_read(32'h8000_0010, d, rs, lat);
    chk("zstrb_word", d, 32'h1155_3344);

    // decode errors on either side of the window
    axi_write(32'h8000_0000, 32'h0BAD_C0DE, 4'hF, rs, lat);
    axi_read(32'h7FFF_FFFC, d, rs, lat);
    chk("oob_rresp", {30'b0, rs}, 32'd3);
    chk("oob_rdata", d, 32'd0);
    axi_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, rs, lat);
    chk("oob_bresp", {30'b0, rs}, 32'd3);
    axi_read(32'h8000_0000, d, rs, lat);
    chk("oob_untouched", d, 32'h0BAD_C0DE);
    axi_read(32'h8000_3FFC, d, rs, lat);
    chk("last_word_rresp", {30'b0, rs}, 32'd0);

    // read backpressure: response held while rready is low
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rvalid", rvalid, 1'b1);
      chk("bp_rdata", rdata, 32'h1155_3344);
      chk1("bp_arready", arready, 1'b0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_arready_after", arready, 1'b1);
    chk1("bp_rvalid_after", rvalid, 1'b0);

    // fill the random window with known words
    for (int i = 0; i < 16; i++) axi_write(BASE + 32'(4 * i), $urandom, 4'hF, rs, lat);
    rand_phase(1500);

    // reset while a write waits in W_RESP and a read waits in R_WAIT
    axi_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF, rs, lat);
    axi_write(32'h8000_0024, 32'h1357_9BDF, 4'hF, rs, lat);
    awaddr = 32'h8000_0028; wdata = 32'h2468_ACE0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    chk1("pre_rst_bvalid", bvalid, 1'b1);
    araddr = 32'h8000_0020; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_bvalid", bvalid, 1'b0);
    chk1("rst_arready", arready, 1'b0);
    chk1("rst_awready", awready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_arready", arready, 1'b1);
    axi_read(32'h8000_0020, d, rs, lat);
    chk("kept_word0", d, 32'hCAFE_F00D);
    axi_read(32'h8000_0028, d, rs, lat);
    chk("kept_word2", d, 32'h2468_ACE0);

    rand_phase(400);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
